// File: rtl/shp_nbr_gen.sv
// rtl/shp_nbr_gen.sv - neighbour-difference generator feeding the sharpness stage
module shp_nbr_gen #(
    parameter int H_ACTIVE = 1920,
    parameter int DW       = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_hs,
    input  logic          i_vs,
    input  logic [DW-1:0] pix_in,
    input  logic          pix_valid,
    output logic          o_hs,
    output logic          o_vs,
    output logic          shp_en,
    output logic [DW-1:0] shp_curr,
    output logic [DW:0]   curr_prev_diff,
    output logic [DW:0]   curr_next_diff,
    output logic          shp_sel,
    output logic          line_err
);

    typedef enum logic [2:0] {IDLE, FIRST, RUN, FLUSH, DONE} state_t;

    localparam logic [11:0] H_LAST = 12'(H_ACTIVE);

    state_t        state, state_nxt;
    logic [DW-1:0] curr_r, prev_r;
    logic [11:0]   cnt;

    logic          accept;
    logic          last_hit;
    logic          emit;
    logic          emit_sel;
    logic [DW-1:0] emit_prev;
    logic [DW-1:0] emit_next;

    assign accept   = pix_valid & i_hs & i_vs &
                      ((state == IDLE) | (state == FIRST) | (state == RUN));
    assign last_hit = ((cnt + 12'd1) == H_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and the neighbour triple to emit this cycle
    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        emit_sel  = 1'b0;
        emit_prev = curr_r;
        emit_next = curr_r;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (H_ACTIVE == 1) ? FLUSH : FIRST;
                end
            end
            FIRST: begin
                if (accept) begin
                    emit      = 1'b1;
                    emit_sel  = 1'b1;
                    emit_prev = curr_r;
                    emit_next = pix_in;
                    state_nxt = last_hit ? FLUSH : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    emit      = 1'b1;
                    emit_prev = prev_r;
                    emit_next = pix_in;
                    state_nxt = last_hit ? FLUSH : RUN;
                end
            end
            FLUSH: begin
                emit      = 1'b1;
                emit_sel  = 1'b1;
                emit_prev = prev_r;
                emit_next = curr_r;
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Blanking overrides everything, including a pending flush
        if (!i_vs || !i_hs) begin
            state_nxt = IDLE;
            emit      = 1'b0;
        end
    end

    // Pixel pipeline, counters, registered outputs and the sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_hs           <= 1'b0;
            o_vs           <= 1'b0;
            curr_r         <= '0;
            prev_r         <= '0;
            cnt            <= '0;
            shp_en         <= 1'b0;
            shp_curr       <= '0;
            curr_prev_diff <= '0;
            curr_next_diff <= '0;
            shp_sel        <= 1'b0;
            line_err       <= 1'b0;
        end else begin
            o_hs <= i_hs;
            o_vs <= i_vs;
            if (!i_vs || !i_hs) begin
                curr_r         <= '0;
                prev_r         <= '0;
                cnt            <= '0;
                shp_en         <= 1'b0;
                shp_curr       <= '0;
                curr_prev_diff <= '0;
                curr_next_diff <= '0;
                shp_sel        <= 1'b0;
                if (!i_vs) begin
                    line_err <= 1'b0;
                end else if ((state == FIRST) || (state == RUN)) begin
                    // Line ended before H_ACTIVE pixels arrived; held pixels are dropped
                    line_err <= 1'b1;
                end
            end else begin
                shp_en <= emit;
                if (emit) begin
                    shp_curr       <= curr_r;
                    curr_prev_diff <= {1'b0, curr_r} - {1'b0, emit_prev};
                    curr_next_diff <= {1'b0, curr_r} - {1'b0, emit_next};
                    shp_sel        <= emit_sel;
                end
                if (accept) begin
                    curr_r <= pix_in;
                    if (state == IDLE) begin
                        cnt <= 12'd1;
                        if (H_ACTIVE == 1) begin
                            prev_r <= pix_in;
                        end
                    end else begin
                        prev_r <= curr_r;
                        cnt    <= cnt + 12'd1;
                    end
                end
                if ((state == DONE) && pix_valid) begin
                    line_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_shp_nbr_gen.sv
// tb/tb_shp_nbr_gen.sv - scoreboard bench for shp_nbr_gen
module tb_shp_nbr_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_hs = 1'b0;
    logic        i_vs = 1'b0;
    logic        pix_valid = 1'b0;
    logic [11:0] pix_in = '0;

    logic [2:0]  hs_o, vs_o, en_o, sel_o, err_o;
    logic [11:0] curr_o [3];
    logic [12:0] pd_o [3];
    logic [12:0] nd_o [3];

    logic        m_hs, m_vs, m_en, m_sel, m_err;
    logic [11:0] m_curr;
    logic [12:0] m_pd, m_nd;

    typedef struct packed {
        logic [11:0] c;
        logic [12:0] pd;
        logic [12:0] nd;
        logic        s;
    } exp_t;

    exp_t sb[$];
    int   px[$];
    int   dsel = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   en_count = 0;

    always #5 clk = ~clk;

    shp_nbr_gen #(.H_ACTIVE(4), .DW(12)) u_h4 (
        .clk(clk), .rst_n(rst_n), .i_hs(i_hs), .i_vs(i_vs), .pix_in(pix_in), .pix_valid(pix_valid),
        .o_hs(hs_o[0]), .o_vs(vs_o[0]), .shp_en(en_o[0]), .shp_curr(curr_o[0]),
        .curr_prev_diff(pd_o[0]), .curr_next_diff(nd_o[0]), .shp_sel(sel_o[0]), .line_err(err_o[0])
    );
    shp_nbr_gen #(.H_ACTIVE(1), .DW(12)) u_h1 (
        .clk(clk), .rst_n(rst_n), .i_hs(i_hs), .i_vs(i_vs), .pix_in(pix_in), .pix_valid(pix_valid),
        .o_hs(hs_o[1]), .o_vs(vs_o[1]), .shp_en(en_o[1]), .shp_curr(curr_o[1]),
        .curr_prev_diff(pd_o[1]), .curr_next_diff(nd_o[1]), .shp_sel(sel_o[1]), .line_err(err_o[1])
    );
    shp_nbr_gen #(.H_ACTIVE(3), .DW(12)) u_h3 (
        .clk(clk), .rst_n(rst_n), .i_hs(i_hs), .i_vs(i_vs), .pix_in(pix_in), .pix_valid(pix_valid),
        .o_hs(hs_o[2]), .o_vs(vs_o[2]), .shp_en(en_o[2]), .shp_curr(curr_o[2]),
        .curr_prev_diff(pd_o[2]), .curr_next_diff(nd_o[2]), .shp_sel(sel_o[2]), .line_err(err_o[2])
    );

    always_comb begin
        m_hs = hs_o[0]; m_vs = vs_o[0]; m_en = en_o[0]; m_sel = sel_o[0]; m_err = err_o[0];
        m_curr = curr_o[0]; m_pd = pd_o[0]; m_nd = nd_o[0];
        case (dsel)
            1: begin
                m_hs = hs_o[1]; m_vs = vs_o[1]; m_en = en_o[1]; m_sel = sel_o[1]; m_err = err_o[1];
                m_curr = curr_o[1]; m_pd = pd_o[1]; m_nd = nd_o[1];
            end
            2: begin
                m_hs = hs_o[2]; m_vs = vs_o[2]; m_en = en_o[2]; m_sel = sel_o[2]; m_err = err_o[2];
                m_curr = curr_o[2]; m_pd = pd_o[2]; m_nd = nd_o[2];
            end
            default: ;
        endcase
    end

    function automatic logic [12:0] dif(input int a, input int b);
        return 13'(a - b);
    endfunction

    function automatic void push_exp(input int c, input logic [12:0] pd, input logic [12:0] nd, input logic s);
        exp_t e;
        e.c = 12'(c); e.pd = pd; e.nd = nd; e.s = s;
        sb.push_back(e);
    endfunction

    // Expected emissions for a line of n pixels (taken from px) on a DUT with h active pixels
    function automatic void push_model(input int n, input int h);
        int ne;
        int p;
        int nx;
        ne = (n >= h) ? h : n - 1;
        for (int k = 0; k < ne; k++) begin
            p  = (k == 0) ? px[k] : px[k-1];
            nx = (k == h - 1) ? px[k] : px[k+1];
            push_exp(px[k], dif(px[k], p), dif(px[k], nx), (k == 0) || (k == h - 1));
        end
    endfunction

    // Scoreboard: every shp_en pulse of the selected DUT pops one expectation
    always @(negedge clk) begin
        if (rst_n && m_en) begin
            exp_t e;
            en_count++;
            if (sb.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected_emission curr=%0d pd=%0h nd=%0h sel=%0b", m_curr, m_pd, m_nd, m_sel);
            end else begin
                e = sb.pop_front();
                vectors++;
                if (m_curr !== e.c) begin miscompares++; $display("FAIL emit_curr got %0d want %0d", m_curr, e.c); end
                vectors++;
                if (m_pd !== e.pd) begin miscompares++; $display("FAIL emit_prev_diff got %0h want %0h", m_pd, e.pd); end
                vectors++;
                if (m_nd !== e.nd) begin miscompares++; $display("FAIL emit_next_diff got %0h want %0h", m_nd, e.nd); end
                vectors++;
                if (m_sel !== e.s) begin miscompares++; $display("FAIL emit_sel got %0b want %0b", m_sel, e.s); end
            end
        end
    end

    task automatic send_pix(input int v);
        @(posedge clk); #1;
        pix_in = 12'(v);
        pix_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            pix_valid = 1'b0;
        end
    endtask

    task automatic drive_line(input int n, input int gap_at, input int gap_len);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) idle(gap_len);
            send_pix(px[i]);
        end
        idle(4);
    endtask

    task automatic new_line(input bit frame);
        @(posedge clk); #1;
        pix_valid = 1'b0;
        i_hs = 1'b0;
        if (frame) i_vs = 1'b0;
        @(posedge clk); #1;
        i_hs = 1'b1;
        i_vs = 1'b1;
        en_count = 0;
    endtask

    task automatic check_drained(input string name);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL %s_pending got %0d want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        dsel = 0;
        #2;
        vectors++; if (m_en !== 1'b0)    begin miscompares++; $display("FAIL reset_en got %0b want 0", m_en); end
        vectors++; if (m_curr !== 12'd0) begin miscompares++; $display("FAIL reset_curr got %0h want 0", m_curr); end
        vectors++; if (m_pd !== 13'd0)   begin miscompares++; $display("FAIL reset_pd got %0h want 0", m_pd); end
        vectors++; if (m_nd !== 13'd0)   begin miscompares++; $display("FAIL reset_nd got %0h want 0", m_nd); end
        vectors++; if (m_sel !== 1'b0)   begin miscompares++; $display("FAIL reset_sel got %0b want 0", m_sel); end
        vectors++; if (m_err !== 1'b0)   begin miscompares++; $display("FAIL reset_err got %0b want 0", m_err); end
        vectors++; if ({m_hs, m_vs} !== 2'b00) begin miscompares++; $display("FAIL reset_sync got %0b want 00", {m_hs, m_vs}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        i_vs = 1'b1;
        idle(2);
        vectors++; if ({m_hs, m_vs} !== 2'b01) begin miscompares++; $display("FAIL sync_delay got %0b want 01", {m_hs, m_vs}); end
        i_hs = 1'b1;
        @(posedge clk); #1;
        vectors++; if ({m_hs, m_vs} !== 2'b11) begin miscompares++; $display("FAIL sync_delay_hs got %0b want 11", {m_hs, m_vs}); end
    endtask

    task automatic test_back_to_back();
        dsel = 0;
        new_line(1'b1);
        px = '{100, 200, 150, 150};
        push_exp(100, 13'd0, dif(100, 200), 1'b1);
        push_exp(200, dif(200, 100), dif(200, 150), 1'b0);
        push_exp(150, dif(150, 200), 13'd0, 1'b0);
        push_exp(150, 13'd0, 13'd0, 1'b1);
        for (int i = 0; i < 4; i++) send_pix(px[i]);
        @(posedge clk); #1;
        pix_valid = 1'b0;
        @(posedge clk); #1;
        vectors++; if ({m_en, m_sel} !== 2'b11) begin miscompares++; $display("FAIL last_emit_timing got %0b want 11", {m_en, m_sel}); end
        @(posedge clk); #1;
        vectors++; if (m_en !== 1'b0) begin miscompares++; $display("FAIL en_after_last got %0b want 0", m_en); end
        idle(2);
        vectors++; if (en_count != 4) begin miscompares++; $display("FAIL b2b_en_count got %0d want 4", en_count); end
        vectors++; if (m_err !== 1'b0) begin miscompares++; $display("FAIL b2b_line_err got %0b want 0", m_err); end
        check_drained("b2b");
    endtask

    task automatic test_bubbles();
        dsel = 0;
        new_line(1'b0);
        px = '{100, 200, 150, 150};
        push_model(4, 4);
        drive_line(4, 2, 3);
        vectors++; if (en_count != 4) begin miscompares++; $display("FAIL bubble_en_count got %0d want 4", en_count); end
        vectors++; if (m_err !== 1'b0) begin miscompares++; $display("FAIL bubble_line_err got %0b want 0", m_err); end
        check_drained("bubble");
    endtask

    task automatic test_single();
        dsel = 1;
        new_line(1'b1);
        px = '{4095};
        push_exp(4095, 13'd0, 13'd0, 1'b1);
        drive_line(1, -1, 0);
        vectors++; if (en_count != 1) begin miscompares++; $display("FAIL single_en_count got %0d want 1", en_count); end
        check_drained("single");
    endtask

    task automatic test_extremes();
        dsel = 2;
        new_line(1'b1);
        px = '{0, 4095, 0};
        push_exp(0, 13'd0, 13'h1001, 1'b1);
        push_exp(4095, 13'h0FFF, 13'h0FFF, 1'b0);
        push_exp(0, 13'h1001, 13'd0, 1'b1);
        drive_line(3, -1, 0);
        vectors++; if (m_err !== 1'b0) begin miscompares++; $display("FAIL extreme_line_err got %0b want 0", m_err); end
        check_drained("extreme");
    endtask

    task automatic test_short_line();
        dsel = 0;
        new_line(1'b1);
        px = '{10, 20};
        push_model(2, 4);
        drive_line(2, -1, 0);
        @(posedge clk); #1;
        i_hs = 1'b0;
        @(posedge clk); #1;
        vectors++; if (en_count != 1) begin miscompares++; $display("FAIL short_en_count got %0d want 1", en_count); end
        vectors++; if (m_err !== 1'b1) begin miscompares++; $display("FAIL short_line_err got %0b want 1", m_err); end
        vectors++;
        if ({m_en, m_sel, m_curr, m_pd, m_nd} !== '0) begin
            miscompares++;
            $display("FAIL short_outputs_zero got curr=%0h pd=%0h nd=%0h en=%0b sel=%0b want 0", m_curr, m_pd, m_nd, m_en, m_sel);
        end
        i_hs = 1'b1;
        idle(2);
        i_hs = 1'b0;
        idle(2);
        vectors++; if (m_err !== 1'b1) begin miscompares++; $display("FAIL short_err_sticky got %0b want 1", m_err); end
        i_vs = 1'b0;
        @(posedge clk); #1;
        vectors++; if (m_err !== 1'b0) begin miscompares++; $display("FAIL short_err_vs_clear got %0b want 0", m_err); end
        i_vs = 1'b1;
        i_hs = 1'b1;
        check_drained("short");
    endtask

    task automatic test_long_line();
        dsel = 0;
        new_line(1'b1);
        px = '{7, 300, 4000, 1, 2};
        push_model(5, 4);
        drive_line(5, 4, 1);
        vectors++; if (en_count != 4) begin miscompares++; $display("FAIL long_en_count got %0d want 4", en_count); end
        vectors++; if (m_err !== 1'b1) begin miscompares++; $display("FAIL long_line_err got %0b want 1", m_err); end
        check_drained("long");
    endtask

    task automatic test_reset_midline();
        dsel = 0;
        new_line(1'b1);
        px = '{5, 6, 7};
        push_model(3, 4);
        for (int i = 0; i < 3; i++) send_pix(px[i]);
        @(posedge clk); #1;
        pix_valid = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({m_en, m_sel, m_err, m_hs, m_vs, m_curr, m_pd, m_nd} !== '0) begin
            miscompares++;
            $display("FAIL midreset_zero got curr=%0h pd=%0h nd=%0h en=%0b sel=%0b err=%0b", m_curr, m_pd, m_nd, m_en, m_sel, m_err);
        end
        check_drained("midreset");
        i_hs = 1'b0;
        i_vs = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        new_line(1'b1);
        px = '{};
        for (int i = 0; i < 4; i++) px.push_back(int'($urandom_range(0, 4095)));
        push_model(4, 4);
        drive_line(4, 1, 2);
        vectors++; if (en_count != 4) begin miscompares++; $display("FAIL restart_en_count got %0d want 4", en_count); end
        vectors++; if (m_err !== 1'b0) begin miscompares++; $display("FAIL restart_line_err got %0b want 0", m_err); end
        check_drained("restart");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_bubbles();
        test_single();
        test_extremes();
        test_short_line();
        test_long_line();
        test_reset_midline();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d vectors", vectors);
        $fatal(1);
    end

endmodule

// File: doc/shp_nbr_gen.md
Name: shp_nbr_gen

Overview:
- Neighbour-difference generator that drives the sharpness stage's input interface.
- Consumes the active-line 12-bit subpixel stream and emits, per pixel:
  - the centre sample (shp_curr),
  - signed differences to the left and right neighbours,
  - a line-edge select (shp_sel),
  - an aligned enable (shp_en).
- Buffers one pixel of look-ahead per line and flushes the last pixel itself.
- Sits directly upstream of the sharpness filter in the SPR pipeline.

Parameters:
- H_ACTIVE, 1920, active pixels per line; legal range 1 to 4095.
- DW, 12, pixel data width; the sharpness interface fixes this at 12.

Ports:
- clk  input  1  pixel clock
- rst_n  input  1  asynchronous active-low reset
- i_hs  input  1  line-active; low = horizontal blanking, synchronously clears line state
- i_vs  input  1  frame-active; low = vertical blanking, synchronously clears all state
- pix_in  input  DW  input subpixel sample
- pix_valid  input  1  pix_in valid this cycle; ignored while i_hs or i_vs is low
- o_hs  output  1  i_hs delayed 1 cycle
- o_vs  output  1  i_vs delayed 1 cycle
- shp_en  output  1  output triple valid this cycle
- shp_curr  output  DW  centre pixel
- curr_prev_diff  output  DW+1  two's-complement (curr - prev)
- curr_next_diff  output  DW+1  two's-complement (curr - next)
- shp_sel  output  1  1 = first or last pixel of the line
- line_err  output  1  sticky: line was short or long; cleared only by i_vs low or reset

Behaviour:
- Reset (rst_n low, asynchronous): every output and internal register is 0, FSM is in IDLE.
- Priority of synchronous clears: i_vs low, then i_hs low, then normal operation.
  - Both clears force FSM to IDLE, zero the pixel counter and zero every output except o_hs/o_vs.
  - Only i_vs low clears line_err.
- Internal state: curr_r and prev_r (DW bits each), cnt (12 bits) counting pixels accepted this line.
- Pixel "accepted" = pix_valid & i_hs & i_vs while the FSM is in IDLE, FIRST or RUN.
- All outputs are registered; shp_en is a single-cycle pulse per emitted pixel.
- FSM:
  - IDLE:
    - On accept: curr_r <= pix_in, cnt <= 1.
    - If H_ACTIVE == 1: prev_r <= pix_in, go to FLUSH. Else go to FIRST.
    - No emission.
  - FIRST:
    - On accept: emit curr_r with prev = curr_r and next = pix_in, shp_sel = 1, so curr_prev_diff = 0.
    - Then prev_r <= curr_r, curr_r <= pix_in, cnt++.
    - Go to FLUSH if cnt + 1 == H_ACTIVE, else RUN.
  - RUN:
    - On accept: emit curr_r with prev = prev_r and next = pix_in, shp_sel = 0.
    - Shift the registers and increment cnt.
    - Go to FLUSH if cnt + 1 == H_ACTIVE.
  - FLUSH:
    - Unconditionally emit curr_r with prev = prev_r and next = curr_r, shp_sel = 1, so curr_next_diff = 0.
    - Go to DONE.
  - DONE:
    - Any pix_valid sets line_err; no emission.
    - Stays in DONE until i_hs low.
- pix_valid low in FIRST/RUN: registers hold and shp_en = 0; bubbles are allowed anywhere in the line.
- Latency: pixel k (k < last) is emitted the cycle after pixel k+1 is accepted; the last pixel is emitted the cycle after it is accepted.
- Arithmetic: differences are computed at DW+1 bits, range -4095..+4095; no saturation needed.
- i_hs falling while in FIRST or RUN (short line):
  - Set line_err.
  - The held pixels are discarded with no emission.
  - Outputs are zeroed the next cycle.
- i_hs falling in the same cycle as an accept: the clear wins and the pixel is dropped.
- o_hs/o_vs are a plain 1-cycle delay, independent of the FSM, so the sharpness stage's clears stay aligned with shp_en.

Test Plan:
- H_ACTIVE=4, pix 100,200,150,150 back-to-back, expected emissions:
  - sel1/diffs 0,-100
  - sel0/100,50
  - sel0/-50,0
  - sel1/0,0
  - shp_en high exactly 4 cycles, the last one the cycle after the 4th pixel.
- Same line with pix_valid low for 3 cycles between pixels 2 and 3 -> identical values, shp_en gaps match the bubbles, no line_err.
- H_ACTIVE=1, pix 4095 -> single emission 4095, sel=1, both diffs 0.
- Extremes H_ACTIVE=3, pix 0,4095,0:
  - first emission: next_diff = -4095 (13'h1001)
  - middle emission: diffs +4095, +4095
- Short line: H_ACTIVE=4, only 2 pixels then i_hs low -> one emission (first pixel), line_err=1, outputs 0; line_err holds through i_hs toggling and clears on i_vs low.
- Long line: 5 pixels with H_ACTIVE=4 -> 4 emissions, line_err=1. Separately, assert rst_n low mid-line -> all outputs 0 immediately, clean restart on the next line.
